fir_coef_ctrl: RTL and testbench
================================

# fir_coef_ctrl

Coefficient bank controller for the 15-tap symmetric FIR. It holds a shadow bank of 8 coefficients (c0c14..c7) written by the processor bus, and on request transfers them atomically into the active bank driving the FIR. The transfer lands on a sample boundary (`syncIn`). The block then tracks the FIR flush interval and reports when the output again reflects only the new coefficients. It sits between the register interface and the FIR instance in the demod channel.

## Interface
Parameters:
- `COEF_W`, 16, coefficient width.
- `FLUSH_LEN`, 16, `syncIn` strobes after a swap before `settled` reasserts (14 delay taps + multiplier register + output register).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `syncIn` in 1: FIR sample strobe.
- `wr` in 1: shadow write strobe.
- `addr` in 3: shadow index; 0=c0c14 … 6=c6c8, 7=c7.
- `din` in COEF_W: write data.
- `swapReq` in 1: request shadow→active transfer.
- `c0c14`,`c1c13`,`c2c12`,`c3c11`,`c4c10`,`c5c9`,`c6c8`,`c7` out COEF_W each: active coefficients, registered.
- `swapPending` out 1: request accepted, transfer not yet done.
- `swapDone` out 1: one-cycle pulse on the transfer edge.
- `settled` out 1: high when no swap is pending or flushing.

## Operation
- Shadow write: `wr`=1 writes `din` into `shadow[addr]` on the edge. Writes are allowed in any state.
- Active bank changes only on the transfer edge. Otherwise it holds.

State machine:
- IDLE → PENDING on `swapReq`=1.
- PENDING: transfer on the first cycle with `syncIn`=1.
  - All 8 active registers are loaded from the shadow in one edge.
  - `swapDone` pulses.
  - Flush counter loads FLUSH_LEN.
  - Next state is FLUSH.
- FLUSH: counter decrements on each `syncIn`. When it reaches 0, go to IDLE.
- FLUSH + `swapReq`=1: abort the flush and go to PENDING. The counter reloads at the next transfer.
- `swapReq` in PENDING: ignored. Still one transfer.

Outputs by state:
- `swapPending` = (state==PENDING).
- `settled` = (state==IDLE).

Boundary rules:
- `wr` and transfer on the same edge: the transfer copies the pre-write shadow value. The write lands in the shadow only, and a further swap is needed to apply it.
- `swapReq` and `syncIn` in the same cycle while IDLE: this only enters PENDING. The transfer waits for a later `syncIn`.
- FLUSH_LEN=0 is illegal.
- Flush counter width is $clog2(FLUSH_LEN+1).

Reset (asynchronous, mid-operation included):
- Shadow and active banks = 0.
- state = IDLE.
- `swapDone`=0, `swapPending`=0, `settled`=1.
- Any pending swap is discarded.

## Timing
- Write latency: shadow is updated 1 edge after `wr`.
- Swap latency: `swapReq` sampled at edge t. The transfer happens at the first edge > t where `syncIn`=1. With `syncIn` every cycle, that is edge t+1.
- Active coefficients change on the same edge `swapDone` rises.
- `settled` rises on the edge where the FLUSH_LEN-th `syncIn` after the transfer is sampled.
- All outputs are registered. There are no combinational input→output paths.

## Configuration
- `FIR_COEF_READBACK_EN` defined:
  - Adds ports `rd` in 1, `rdActive` in 1 and `dout` out COEF_W.
  - `dout` is registered, 1 cycle after `rd`.
  - It returns `active[addr]` if `rdActive`, else `shadow[addr]`.
  - `dout` resets to 0 and holds when `rd`=0.
- Not defined: these ports and their logic are absent. Bus writes are write-only.

## Structure
- Package `fir_ctrl_pkg`:
  - `NUM_COEF`=8.
  - Address constants `ADDR_C0C14`..`ADDR_C7`.
  - State enum {IDLE, PENDING, FLUSH}.
  - Default `FLUSH_LEN`.
- Sub-module `fir_coef_bank`: an 8×COEF_W register file with write port, parallel load, and flat outputs. It is instantiated twice, once as shadow and once as active.
- The state machine and counter live in the top level.

## Test plan
- Reset then idle:
  - All 8 coefficient outputs = 0, `settled`=1, `swapPending`=0.
  - Writing addr 3 = 0x1234 leaves `c3c11`=0.
- Basic swap:
  - Write 0x0100..0x0107 to addr 0..7, pulse `swapReq`, assert `syncIn` 5 cycles later.
  - Outputs update on that `syncIn` edge with `swapDone` pulsed.
  - `settled` returns to 1 after exactly 16 `syncIn` strobes.
- Collision:
  - Write addr 7 = 0x7FFF on the transfer edge (shadow was 0x0107).
  - `c7`=0x0107 after transfer.
  - A second swap gives `c7`=0x7FFF.
- Swap during flush:
  - `swapReq` after 5 flush strobes goes to PENDING with `settled` staying 0.
  - After the next transfer, 16 strobes are needed before `settled`=1.
- Async reset:
  - Assert `reset` low mid-PENDING between clock edges.
  - Outputs clear immediately, and no transfer occurs on later `syncIn`.
- With `FIR_COEF_READBACK_EN`:
  - After the basic swap, `rd` addr 2 with `rdActive`=1 returns 0x0102 on the next cycle.
  - Shadow readback returns the last written value.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
// Shared constants, address map and state encoding for the FIR coefficient controller.
package fir_ctrl_pkg;

    localparam int NUM_COEF          = 8;
    localparam int ADDR_W            = 3;
    localparam int FLUSH_LEN_DEFAULT = 16;

    localparam logic [ADDR_W-1:0] ADDR_C0C14 = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_C1C13 = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_C2C12 = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_C3C11 = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_C4C10 = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_C5C9  = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_C6C8  = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_C7    = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        FLUSH   = 2'd2
    } state_e;

endpackage

// File: rtl/fir_coef_bank.sv
// 8 x COEF_W coefficient register file: single write port, whole-bank parallel load, flat output.
module fir_coef_bank
    import fir_ctrl_pkg::*;
#(
    parameter int COEF_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [COEF_W-1:0]          wr_data,
    input  logic                       load_en,
    input  logic [NUM_COEF*COEF_W-1:0] load_data,
    output logic [NUM_COEF*COEF_W-1:0] bank_flat
);

    logic [COEF_W-1:0] bank_q [NUM_COEF];
    logic [COEF_W-1:0] bank_d [NUM_COEF];

    // Next-state per entry; a parallel load overrides any single-entry write.
    always_comb begin
        for (int i = 0; i < NUM_COEF; i++) begin
            bank_d[i] = bank_q[i];
            if (load_en) begin
                bank_d[i] = load_data[i*COEF_W +: COEF_W];
            end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                bank_d[i] = wr_data;
            end else begin
                bank_d[i] = bank_q[i];
            end
        end
    end

    // Register file storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COEF; i++) begin
                bank_q[i] <= {COEF_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_COEF; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_COEF; g++) begin : g_flat
        assign bank_flat[g*COEF_W +: COEF_W] = bank_q[g];
    end

endmodule

// File: rtl/fir_coef_ctrl.sv
// Shadow/active coefficient banks with sample-aligned atomic swap and flush tracking.
// Optional readback port enabled by defining FIR_COEF_READBACK_EN.
module fir_coef_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int COEF_W    = 16,
    parameter int FLUSH_LEN = FLUSH_LEN_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              syncIn,
    input  logic              wr,
    input  logic [2:0]        addr,
    input  logic [COEF_W-1:0] din,
    input  logic              swapReq,
`ifdef FIR_COEF_READBACK_EN
    input  logic              rd,
    input  logic              rdActive,
    output logic [COEF_W-1:0] dout,
`endif
    output logic [COEF_W-1:0] c0c14,
    output logic [COEF_W-1:0] c1c13,
    output logic [COEF_W-1:0] c2c12,
    output logic [COEF_W-1:0] c3c11,
    output logic [COEF_W-1:0] c4c10,
    output logic [COEF_W-1:0] c5c9,
    output logic [COEF_W-1:0] c6c8,
    output logic [COEF_W-1:0] c7,
    output logic              swapPending,
    output logic              swapDone,
    output logic              settled
);

    localparam int              CNT_W      = $clog2(FLUSH_LEN + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       swap_done_q, swap_done_d;
    logic                       pending_q, pending_d;
    logic                       settled_q, settled_d;
    logic                       transfer_s;
    logic [NUM_COEF*COEF_W-1:0] shadow_flat_s;
    logic [NUM_COEF*COEF_W-1:0] active_flat_s;

    fir_coef_bank #(.COEF_W(COEF_W)) u_shadow (
        .clk       (clk),
        .rst_n     (reset),
        .wr_en     (wr),
        .wr_addr   (addr),
        .wr_data   (din),
        .load_en   (1'b0),
        .load_data ({(NUM_COEF*COEF_W){1'b0}}),
        .bank_flat (shadow_flat_s)
    );

    // Loads from the registered shadow, so a same-edge write is not seen by the transfer.
    fir_coef_bank #(.COEF_W(COEF_W)) u_active (
        .clk       (clk),
        .rst_n     (reset),
        .wr_en     (1'b0),
        .wr_addr   (ADDR_C0C14),
        .wr_data   ({COEF_W{1'b0}}),
        .load_en   (transfer_s),
        .load_data (shadow_flat_s),
        .bank_flat (active_flat_s)
    );

    // Swap state machine and flush counter next-state logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        swap_done_d = 1'b0;
        transfer_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (swapReq) begin
                    state_d = PENDING;
                end else begin
                    state_d = IDLE;
                end
            end
            PENDING: begin
                if (syncIn) begin
                    transfer_s  = 1'b1;
                    swap_done_d = 1'b1;
                    cnt_d       = FLUSH_LOAD;
                    state_d     = FLUSH;
                end else begin
                    state_d = PENDING;
                end
            end
            FLUSH: begin
                // A new request abandons the current flush; the counter reloads at the next transfer.
                if (swapReq) begin
                    state_d = PENDING;
                end else if (syncIn) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FLUSH;
                    end
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        pending_d = (state_d == PENDING);
        settled_d = (state_d == IDLE);
    end

    // Control state and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            swap_done_q <= 1'b0;
            pending_q   <= 1'b0;
            settled_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            swap_done_q <= swap_done_d;
            pending_q   <= pending_d;
            settled_q   <= settled_d;
        end
    end

    assign swapDone    = swap_done_q;
    assign swapPending = pending_q;
    assign settled     = settled_q;

    assign c0c14 = active_flat_s[0*COEF_W +: COEF_W];
    assign c1c13 = active_flat_s[1*COEF_W +: COEF_W];
    assign c2c12 = active_flat_s[2*COEF_W +: COEF_W];
    assign c3c11 = active_flat_s[3*COEF_W +: COEF_W];
    assign c4c10 = active_flat_s[4*COEF_W +: COEF_W];
    assign c5c9  = active_flat_s[5*COEF_W +: COEF_W];
    assign c6c8  = active_flat_s[6*COEF_W +: COEF_W];
    assign c7    = active_flat_s[7*COEF_W +: COEF_W];

`ifdef FIR_COEF_READBACK_EN
    logic [COEF_W-1:0] dout_q, dout_d;

    // Readback mux; holds the last value while rd is low.
    always_comb begin
        dout_d = dout_q;
        if (rd) begin
            for (int i = 0; i < NUM_COEF; i++) begin
                if (addr == ADDR_W'(i)) begin
                    if (rdActive) begin
                        dout_d = active_flat_s[i*COEF_W +: COEF_W];
                    end else begin
                        dout_d = shadow_flat_s[i*COEF_W +: COEF_W];
                    end
                end else begin
                    dout_d = dout_d;
                end
            end
        end else begin
            dout_d = dout_q;
        end
    end

    // Readback data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q <= {COEF_W{1'b0}};
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
`endif

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed self-checking bench for fir_coef_ctrl (readback section active with FIR_COEF_READBACK_EN).
module tb_fir_coef_ctrl;

    localparam int COEF_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              syncIn;
    logic              wr;
    logic [2:0]        addr;
    logic [COEF_W-1:0] din;
    logic              swapReq;
    logic [COEF_W-1:0] c0c14, c1c13, c2c12, c3c11, c4c10, c5c9, c6c8, c7;
    logic              swapPending, swapDone, settled;
`ifdef FIR_COEF_READBACK_EN
    logic              rd;
    logic              rdActive;
    logic [COEF_W-1:0] dout;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_coef_ctrl #(.COEF_W(COEF_W), .FLUSH_LEN(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .syncIn      (syncIn),
        .wr          (wr),
        .addr        (addr),
        .din         (din),
        .swapReq     (swapReq),
`ifdef FIR_COEF_READBACK_EN
        .rd          (rd),
        .rdActive    (rdActive),
        .dout        (dout),
`endif
        .c0c14       (c0c14),
        .c1c13       (c1c13),
        .c2c12       (c2c12),
        .c3c11       (c3c11),
        .c4c10       (c4c10),
        .c5c9        (c5c9),
        .c6c8        (c6c8),
        .c7          (c7),
        .swapPending (swapPending),
        .swapDone    (swapDone),
        .settled     (settled)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [2:0] a, input logic [COEF_W-1:0] d);
        wr = 1'b1; addr = a; din = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic check_bank(input string tag, input logic [COEF_W-1:0] base);
        check({tag, "_c0"}, {16'd0, c0c14}, {16'd0, base + 16'd0});
        check({tag, "_c1"}, {16'd0, c1c13}, {16'd0, base + 16'd1});
        check({tag, "_c2"}, {16'd0, c2c12}, {16'd0, base + 16'd2});
        check({tag, "_c3"}, {16'd0, c3c11}, {16'd0, base + 16'd3});
        check({tag, "_c4"}, {16'd0, c4c10}, {16'd0, base + 16'd4});
        check({tag, "_c5"}, {16'd0, c5c9},  {16'd0, base + 16'd5});
        check({tag, "_c6"}, {16'd0, c6c8},  {16'd0, base + 16'd6});
        check({tag, "_c7"}, {16'd0, c7},    {16'd0, base + 16'd7});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_c0"}, {16'd0, c0c14}, 32'd0);
        check({tag, "_c1"}, {16'd0, c1c13}, 32'd0);
        check({tag, "_c2"}, {16'd0, c2c12}, 32'd0);
        check({tag, "_c3"}, {16'd0, c3c11}, 32'd0);
        check({tag, "_c4"}, {16'd0, c4c10}, 32'd0);
        check({tag, "_c5"}, {16'd0, c5c9},  32'd0);
        check({tag, "_c6"}, {16'd0, c6c8},  32'd0);
        check({tag, "_c7"}, {16'd0, c7},    32'd0);
    endtask

    initial begin
        reset = 1'b0; syncIn = 1'b0; wr = 1'b0; addr = 3'd0; din = 16'd0; swapReq = 1'b0;
`ifdef FIR_COEF_READBACK_EN
        rd = 1'b0; rdActive = 1'b0;
`endif
        // Reset and idle
        tick(); tick();
        check_zero("rst");
        check("rst_settled", {31'd0, settled}, 32'd1);
        check("rst_pending", {31'd0, swapPending}, 32'd0);
        check("rst_done", {31'd0, swapDone}, 32'd0);
        reset = 1'b1;
        tick();
        write(3'd3, 16'h1234);
        check("idle_wr_c3", {16'd0, c3c11}, 32'h0000);
        check("idle_wr_settled", {31'd0, settled}, 32'd1);

        // Basic swap
        for (int i = 0; i < 8; i++) write(3'(i), 16'h0100 + 16'(i));
        swapReq = 1'b1; tick(); swapReq = 1'b0;
        check("bs_pending", {31'd0, swapPending}, 32'd1);
        check("bs_settled0", {31'd0, settled}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("bs_wait_c0", {16'd0, c0c14}, 32'h0000);
        check("bs_wait_pending", {31'd0, swapPending}, 32'd1);
        syncIn = 1'b1; tick(); syncIn = 1'b0;
        check("bs_done", {31'd0, swapDone}, 32'd1);
        check("bs_pending_clr", {31'd0, swapPending}, 32'd0);
        check_bank("bs", 16'h0100);
        tick();
        check("bs_done_pulse", {31'd0, swapDone}, 32'd0);
`ifdef FIR_COEF_READBACK_EN
        rd = 1'b1; rdActive = 1'b1; addr = 3'd2; tick(); rd = 1'b0;
        check("rb_active_a2", {16'd0, dout}, 32'h0102);
        rd = 1'b1; rdActive = 1'b0; addr = 3'd3; tick(); rd = 1'b0;
        check("rb_shadow_a3", {16'd0, dout}, 32'h0103);
        addr = 3'd0; tick();
        check("rb_hold", {16'd0, dout}, 32'h0103);
`endif
        for (int i = 0; i < 15; i++) begin
            syncIn = 1'b1; tick(); syncIn = 1'b0; tick();
        end
        check("bs_settled_15", {31'd0, settled}, 32'd0);
        syncIn = 1'b1; tick(); syncIn = 1'b0;
        check("bs_settled_16", {31'd0, settled}, 32'd1);

        // Collision: write on the transfer edge
        swapReq = 1'b1; tick(); swapReq = 1'b0;
        syncIn = 1'b1; wr = 1'b1; addr = 3'd7; din = 16'h7FFF;
        tick();
        syncIn = 1'b0; wr = 1'b0;
        check("col_done", {31'd0, swapDone}, 32'd1);
        check("col_c7_old", {16'd0, c7}, 32'h0107);
        swapReq = 1'b1; tick(); swapReq = 1'b0;
        check("col_abort_pending", {31'd0, swapPending}, 32'd1);
        check("col_abort_settled", {31'd0, settled}, 32'd0);
        syncIn = 1'b1; tick(); syncIn = 1'b0;
        check("col_c7_new", {16'd0, c7}, 32'h7FFF);

        // Swap during flush
        syncIn = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        syncIn = 1'b0;
        check("sdf_flushing", {31'd0, settled}, 32'd0);
        swapReq = 1'b1; tick(); swapReq = 1'b0;
        check("sdf_pending", {31'd0, swapPending}, 32'd1);
        check("sdf_settled", {31'd0, settled}, 32'd0);
        syncIn = 1'b1; tick();
        check("sdf_done", {31'd0, swapDone}, 32'd1);
        for (int i = 0; i < 15; i++) tick();
        check("sdf_settled_15", {31'd0, settled}, 32'd0);
        tick(); syncIn = 1'b0;
        check("sdf_settled_16", {31'd0, settled}, 32'd1);

        // swapReq with syncIn while idle only enters PENDING
        write(3'd0, 16'hABCD);
        swapReq = 1'b1; syncIn = 1'b1; tick(); swapReq = 1'b0;
        check("same_pending", {31'd0, swapPending}, 32'd1);
        check("same_no_done", {31'd0, swapDone}, 32'd0);
        check("same_c0_old", {16'd0, c0c14}, 32'h0100);
        tick(); syncIn = 1'b0;
        check("same_done", {31'd0, swapDone}, 32'd1);
        check("same_c0_new", {16'd0, c0c14}, 32'hABCD);

        // Async reset mid-PENDING
        write(3'd1, 16'h5555);
        swapReq = 1'b1; tick(); swapReq = 1'b0;
        check("ar_pending", {31'd0, swapPending}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_zero("ar");
        check("ar_pending_clr", {31'd0, swapPending}, 32'd0);
        check("ar_settled", {31'd0, settled}, 32'd1);
        #2 reset = 1'b1;
        syncIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar_no_done", {31'd0, swapDone}, 32'd0);
        end
        syncIn = 1'b0;
        check("ar_c1", {16'd0, c1c13}, 32'h0000);
        check("ar_settled_after", {31'd0, settled}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
